// File: rtl/aurora_tx_arb.sv
// Packet-level arbiter that shares the single Aurora TX AXI-Stream port between the
// sequence-numbering stage (src0) and the loopback FIFO (src1), switching only on packet boundaries.
module aurora_tx_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int GAP_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic                  link_up,
    input  logic [1:0]            ctrl_mode,
    input  logic [GAP_WIDTH-1:0]  ctrl_gap,
    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  active_src,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stat_pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  stat_pkt_cnt1,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic                 active_q, active_d;
    logic                 last_src_q, last_src_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;
    logic                 inc0, inc1;
    logic                 pick_valid, pick;

    // Source selection, only consumed while IDLE; link_up gates new grants only.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 1'b0;
        if (link_up) begin
            case (ctrl_mode)
                2'b00: begin
                    pick_valid = s0_axis_tvalid;
                    pick       = 1'b0;
                end
                2'b01: begin
                    pick_valid = s1_axis_tvalid;
                    pick       = 1'b1;
                end
                2'b10: begin
                    pick_valid = s0_axis_tvalid | s1_axis_tvalid;
                    if (s0_axis_tvalid && s1_axis_tvalid) pick = ~last_src_q;
                    else                                  pick = s1_axis_tvalid;
                end
                default: begin
                    pick_valid = s0_axis_tvalid | s1_axis_tvalid;
                    pick       = ~s0_axis_tvalid;
                end
            endcase
        end
    end

    // AXI-Stream: a beat transfers on a cycle where tvalid and tready are both high; the
    // granted source sees m_axis_tready directly, so data, valid and ready pass with no latency.
    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        active_d       = active_q;
        last_src_d     = last_src_q;
        inc0           = 1'b0;
        inc1           = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    active_d = pick;
                    state_d  = PASS;
                end
            end
            PASS: begin
                if (active_q) begin
                    m_axis_tvalid  = s1_axis_tvalid;
                    m_axis_tdata   = s1_axis_tdata;
                    m_axis_tlast   = s1_axis_tlast;
                    s1_axis_tready = m_axis_tready;
                end else begin
                    m_axis_tvalid  = s0_axis_tvalid;
                    m_axis_tdata   = s0_axis_tdata;
                    m_axis_tlast   = s0_axis_tlast;
                    s0_axis_tready = m_axis_tready;
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    last_src_d = active_q;
                    inc0       = ~active_q;
                    inc1       = active_q;
                    if (ctrl_gap == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = ctrl_gap;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            active_q   <= 1'b0;
            last_src_q <= 1'b1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            active_q   <= active_d;
            last_src_q <= last_src_d;
            if (inc0) cnt0_q <= cnt0_q + 1'b1;
            if (inc1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign active_src    = active_q;
    assign stat_pkt_cnt0 = cnt0_q;
    assign stat_pkt_cnt1 = cnt1_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Directed bench for aurora_tx_arb: drivers push hand-computed beats into exp_q and a
// negedge monitor pops and compares every beat accepted on the master port.
module tb_aurora_tx_arb;

    localparam int DW = 32;
    localparam int GW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_up;
    logic [1:0]    ctrl_mode;
    logic [GW-1:0] ctrl_gap;
    logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic [DW-1:0] s0_axis_tdata;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic [DW-1:0] s1_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          active_src, busy;
    logic [CW-1:0] stat_pkt_cnt0, stat_pkt_cnt1;
    logic [1:0]    fsm_state;

    aurora_tx_arb #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .link_up        (link_up),
        .ctrl_mode      (ctrl_mode),
        .ctrl_gap       (ctrl_gap),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .active_src     (active_src),
        .busy           (busy),
        .stat_pkt_cnt0  (stat_pkt_cnt0),
        .stat_pkt_cnt1  (stat_pkt_cnt1),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [33:0]   exp_q[$];
    int            beat_cyc[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cnt0 = '0;
    logic [CW-1:0] exp_cnt1 = '0;
    logic          starve_watch = 1'b0;
    int            s1_rdy_cnt = 0;
    logic [33:0]   mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got src %0d data 0x%0h, expected no beat",
                         active_src, m_axis_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_src_last_data", {30'd0, active_src, m_axis_tlast, m_axis_tdata},
                    {30'd0, mon_e});
                chk("other_tready", {63'd0, active_src ? s0_axis_tready : s1_axis_tready}, 64'd0);
            end
        end
        if (starve_watch && s1_axis_tready) s1_rdy_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic src_ready(input logic src);
        return src ? s1_axis_tready : s0_axis_tready;
    endfunction

    task automatic push_pkt(input logic src, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({src, (i == n - 1), base + 32'(i)});
        if (src) exp_cnt1++;
        else     exp_cnt0++;
    endtask

    // Entered one time unit after a rising edge; returns at the same phase after the last beat.
    task automatic send(input logic src, input logic [31:0] base, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if (src) begin
                s1_axis_tvalid = 1'b1;
                s1_axis_tdata  = base + 32'(i);
                s1_axis_tlast  = (i == n - 1);
            end else begin
                s0_axis_tvalid = 1'b1;
                s0_axis_tdata  = base + 32'(i);
                s0_axis_tlast  = (i == n - 1);
            end
            #1;
            t = 0;
            while (!src_ready(src) && t < 300) begin
                @(posedge clk);
                #2;
                t++;
            end
            if (!src_ready(src)) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: src %0d beat %0d not accepted, expected ready within 300 cycles",
                         src, i);
            end
            tick();
        end
    endtask

    task automatic release_src(input logic src);
        if (src) begin
            s1_axis_tvalid = 1'b0;
            s1_axis_tlast  = 1'b0;
            s1_axis_tdata  = '0;
        end else begin
            s0_axis_tvalid = 1'b0;
            s0_axis_tlast  = 1'b0;
            s0_axis_tdata  = '0;
        end
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_cyc.size() < n && t < 500) begin
            tick();
            t++;
        end
        if (beat_cyc.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_beats_timeout: got %0d beats, expected %0d", beat_cyc.size(), n);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_cnt0"}, {56'd0, stat_pkt_cnt0}, {56'd0, exp_cnt0});
        chk({name, "_cnt1"}, {56'd0, stat_pkt_cnt1}, {56'd0, exp_cnt1});
    endtask

    // ---------------- directed tests ----------------
    int t0, t_link;
    int rr_off[8] = '{0, 1, 3, 4, 6, 7, 9, 10};

    initial begin
        rst_n          = 1'b0;
        link_up        = 1'b1;
        ctrl_mode      = 2'b00;
        ctrl_gap       = '0;
        m_axis_tready  = 1'b1;
        release_src(1'b0);
        release_src(1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_master", {62'd0, m_axis_tvalid, m_axis_tlast}, 64'd0);
        chk("reset_tdata", {32'd0, m_axis_tdata}, 64'd0);
        chk("reset_readys_busy", {61'd0, s0_axis_tready, s1_axis_tready, busy}, 64'd0);
        chk("reset_state_src", {61'd0, fsm_state, active_src}, 64'd0);
        chk("reset_counts", {48'd0, stat_pkt_cnt0, stat_pkt_cnt1}, 64'd0);
        rst_n = 1'b1;
        tick();

        // mode 00 serves only src0 even with src1 waiting; switching to 01 then serves src1
        beat_cyc.delete();
        push_pkt(1'b0, 32'hA0, 4);
        push_pkt(1'b1, 32'hF0, 2);
        t0 = cyc;
        fork
            begin
                send(1'b0, 32'hA0, 4);
                ctrl_mode = 2'b01;
                release_src(1'b0);
            end
            begin
                send(1'b1, 32'hF0, 2);
                release_src(1'b1);
            end
        join
        drain("mode00");
        chk("mode00_first_beat_latency", 64'(beat_cyc[0] - t0), 64'd1);
        chk("mode00_burst_len", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
        chk("mode01_switch_gap", 64'(beat_cyc[4] - beat_cyc[3]), 64'd2);

        // round-robin with both sources back-to-back: 0,1,0,1 with one idle cycle each
        ctrl_mode = 2'b10;
        beat_cyc.delete();
        push_pkt(1'b0, 32'hD0, 2);
        push_pkt(1'b1, 32'hE0, 2);
        push_pkt(1'b0, 32'hD2, 2);
        push_pkt(1'b1, 32'hE2, 2);
        fork
            begin
                send(1'b0, 32'hD0, 2);
                send(1'b0, 32'hD2, 2);
                release_src(1'b0);
            end
            begin
                send(1'b1, 32'hE0, 2);
                send(1'b1, 32'hE2, 2);
                release_src(1'b1);
            end
        join
        drain("rr");
        for (int i = 1; i < 8; i++)
            chk("rr_beat_timing", 64'(beat_cyc[i] - beat_cyc[0]), 64'(rr_off[i]));

        // fixed priority: src1 starves while src0 keeps requesting
        ctrl_mode = 2'b11;
        push_pkt(1'b0, 32'h1100, 1);
        push_pkt(1'b0, 32'h1101, 1);
        push_pkt(1'b0, 32'h1102, 1);
        push_pkt(1'b1, 32'h2200, 2);
        s1_rdy_cnt   = 0;
        starve_watch = 1'b1;
        fork
            begin
                send(1'b0, 32'h1100, 1);
                send(1'b0, 32'h1101, 1);
                send(1'b0, 32'h1102, 1);
                release_src(1'b0);
                starve_watch = 1'b0;
            end
            begin
                send(1'b1, 32'h2200, 2);
                release_src(1'b1);
            end
        join
        drain("prio");
        chk("prio_s1_tready_starved", 64'(s1_rdy_cnt), 64'd0);

        // gap of 5: six idle cycles between the tlast beat and the next beat
        ctrl_mode = 2'b00;
        ctrl_gap  = 16'd5;
        beat_cyc.delete();
        push_pkt(1'b0, 32'h500, 1);
        push_pkt(1'b0, 32'h501, 1);
        fork
            begin
                send(1'b0, 32'h500, 1);
                send(1'b0, 32'h501, 1);
                release_src(1'b0);
            end
            begin
                wait_beats(1);
                tick();
                chk("gap_busy_state", {61'd0, busy, fsm_state}, {61'd0, 1'b1, 2'd2});
                chk("gap_no_valid", {63'd0, m_axis_tvalid}, 64'd0);
            end
        join
        drain("gap");
        chk("gap_beat_spacing", 64'(beat_cyc[1] - beat_cyc[0]), 64'd7);
        ctrl_gap = '0;
        tick();

        // downstream stall plus link loss mid-packet: no loss, no switch, no grant while down
        ctrl_mode = 2'b11;
        beat_cyc.delete();
        push_pkt(1'b0, 32'hB0, 4);
        push_pkt(1'b1, 32'hC80, 1);
        fork
            begin
                send(1'b0, 32'hB0, 4);
                release_src(1'b0);
            end
            begin
                wait_beats(2);
                m_axis_tready = 1'b0;
                link_up       = 1'b0;
                repeat (3) tick();
                m_axis_tready = 1'b1;
                wait_beats(4);
                repeat (4) tick();
                chk("linkdown_no_grant", {61'd0, m_axis_tvalid, s1_axis_tready, busy}, 64'd0);
                link_up = 1'b1;
                t_link  = cyc;
            end
            begin
                wait_beats(2);
                send(1'b1, 32'hC80, 1);
                release_src(1'b1);
            end
        join
        drain("stall");
        chk("stall_beat_spacing", 64'(beat_cyc[2] - beat_cyc[1]), 64'd4);
        chk("linkup_grant_timing", 64'(beat_cyc[4] - t_link), 64'd1);

        // reset in the middle of a 4-beat packet
        ctrl_mode = 2'b00;
        exp_q.push_back({1'b0, 1'b0, 32'hC0});
        exp_q.push_back({1'b0, 1'b0, 32'hC1});
        s0_axis_tvalid = 1'b1;
        s0_axis_tdata  = 32'hC0;
        s0_axis_tlast  = 1'b0;
        tick();
        tick();
        s0_axis_tdata = 32'hC1;
        tick();
        s0_axis_tdata = 32'hC2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_master", {30'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 64'd0);
        chk("midrst_readys_busy", {61'd0, s0_axis_tready, s1_axis_tready, busy}, 64'd0);
        chk("midrst_state_src", {61'd0, fsm_state, active_src}, 64'd0);
        chk("midrst_counts", {48'd0, stat_pkt_cnt0, stat_pkt_cnt1}, 64'd0);
        chk("midrst_partial_consumed", 64'(exp_q.size()), 64'd0);
        release_src(1'b0);
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // packet counter wraps from all-ones to zero
        for (int i = 0; i < 255; i++) begin
            push_pkt(1'b0, 32'h7000 + 32'(i), 1);
            send(1'b0, 32'h7000 + 32'(i), 1);
        end
        release_src(1'b0);
        drain("wrap_pre");
        chk("wrap_at_max", {56'd0, stat_pkt_cnt0}, 64'hFF);
        push_pkt(1'b0, 32'h7FFF, 1);
        send(1'b0, 32'h7FFF, 1);
        release_src(1'b0);
        drain("wrap_post");
        chk("wrap_to_zero", {56'd0, stat_pkt_cnt0}, 64'd0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
